// File: rtl/cfg_types_pkg.sv
// Shared types and AXI encodings for the accelerator AXI master bridge.
package cfg_types_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WR_RESP = 3'd2,
        READ    = 3'd3,
        RD_DATA = 3'd4
    } axi_mst_state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Both SLVERR and DECERR are reported to the accelerator as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle with master and slave views.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 2,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/accel_axi_master_bridge.sv
// Bridges the accelerator req/gnt/rvalid memory bus onto single-beat AXI4 master
// transactions, one outstanding at a time.
module accel_axi_master_bridge
    import cfg_types_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 2,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mem_req,
    output logic                        mem_gnt,
    input  logic [AXI_ADDR_WIDTH-1:0]   mem_addr,
    input  logic                        mem_we,
    input  logic [AXI_DATA_WIDTH/8-1:0] mem_be,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_wdata,
    output logic                        mem_rvalid,
    output logic [AXI_DATA_WIDTH-1:0]   mem_rdata,
    output logic                        mem_err,
    output logic                        busy,
    AXI_BUS.Master                      axi_master
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam logic [2:0]  AXI_SIZE   = 3'(ADDR_LSB);

    axi_mst_state_t state_q, state_d;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [STRB_WIDTH-1:0]     be_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic                      aw_done_q;
    logic                      w_done_q;
    logic                      rvalid_q;
    logic                      err_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

    assign mem_gnt = mem_req && (state_q == IDLE);
    assign busy    = (state_q != IDLE);

    // Each write channel drops its valid independently once its own handshake is seen.
    assign aw_valid = (state_q == WRITE) && !aw_done_q;
    assign w_valid  = (state_q == WRITE) && !w_done_q;
    assign ar_valid = (state_q == READ);
    assign b_ready  = (state_q == WR_RESP);
    assign r_ready  = (state_q == RD_DATA);

    assign aw_hs = aw_valid && axi_master.aw_ready;
    assign w_hs  = w_valid && axi_master.w_ready;
    assign ar_hs = ar_valid && axi_master.ar_ready;
    assign b_hs  = b_ready && axi_master.b_valid;
    assign r_hs  = r_ready && axi_master.r_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mem_gnt) state_d = mem_we ? WRITE : READ;
            WRITE:   if (aw_done_q && w_done_q) state_d = WR_RESP;
            WR_RESP: if (b_hs) state_d = IDLE;
            READ:    if (ar_hs) state_d = RD_DATA;
            RD_DATA: if (r_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= b_hs || r_hs;

            if (mem_gnt) begin
                addr_q  <= {mem_addr[AXI_ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
                be_q    <= mem_be;
                wdata_q <= mem_wdata;
            end

            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (b_hs) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                err_q     <= resp_is_err(axi_master.b_resp);
            end

            if (r_hs) begin
                err_q   <= resp_is_err(axi_master.r_resp);
                rdata_q <= axi_master.r_data;
            end
        end
    end

    assign mem_rvalid = rvalid_q;
    assign mem_err    = err_q;
    assign mem_rdata  = rdata_q;

    assign axi_master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_master.aw_addr   = addr_q;
    assign axi_master.aw_len    = 8'd0;
    assign axi_master.aw_size   = AXI_SIZE;
    assign axi_master.aw_burst  = AXI_BURST_INCR;
    assign axi_master.aw_lock   = 1'b0;
    assign axi_master.aw_cache  = 4'd0;
    assign axi_master.aw_prot   = 3'd0;
    assign axi_master.aw_qos    = 4'd0;
    assign axi_master.aw_region = 4'd0;
    assign axi_master.aw_user   = '0;
    assign axi_master.aw_valid  = aw_valid;

    assign axi_master.w_data  = wdata_q;
    assign axi_master.w_strb  = be_q;
    assign axi_master.w_last  = 1'b1;
    assign axi_master.w_user  = '0;
    assign axi_master.w_valid = w_valid;

    assign axi_master.b_ready = b_ready;

    assign axi_master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_master.ar_addr   = addr_q;
    assign axi_master.ar_len    = 8'd0;
    assign axi_master.ar_size   = AXI_SIZE;
    assign axi_master.ar_burst  = AXI_BURST_INCR;
    assign axi_master.ar_lock   = 1'b0;
    assign axi_master.ar_cache  = 4'd0;
    assign axi_master.ar_prot   = 3'd0;
    assign axi_master.ar_qos    = 4'd0;
    assign axi_master.ar_region = 4'd0;
    assign axi_master.ar_user   = '0;
    assign axi_master.ar_valid  = ar_valid;

    assign axi_master.r_ready = r_ready;

    // Response IDs, user bits and RLAST are deliberately ignored: any single beat completes.
    logic unused_resp_fields;
    assign unused_resp_fields = ^{axi_master.b_id, axi_master.b_user, axi_master.r_id,
                                  axi_master.r_last, axi_master.r_user};

endmodule

// File: tb/tb_accel_axi_master_bridge.sv
// Directed self-checking bench for accel_axi_master_bridge with a hand-driven AXI slave.
module tb_accel_axi_master_bridge;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        busy;

    int total;
    int bad;

    AXI_BUS #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH  (2),
        .AXI_USER_WIDTH(1)
    ) axi ();

    accel_axi_master_bridge #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH  (2),
        .AXI_USER_WIDTH(1),
        .AXI_ID        (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .busy      (busy),
        .axi_master(axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one read with an always-ready AR slave; reports grant, latency and result.
    task automatic run_read(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, output logic gnt_seen, output int lat,
                            output logic [31:0] rd, output logic err);
        logic done;
        done = 1'b0;
        lat  = 0;
        rd   = 'x;
        err  = 1'bx;
        axi.ar_ready = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = addr;
        #1;
        gnt_seen = mem_gnt;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            mem_req     = 1'b0;
            lat         = lat + 1;
            axi.r_valid = 1'b0;
            if (mem_rvalid) begin
                done = 1'b1;
                rd   = mem_rdata;
                err  = mem_err;
            end else if (axi.r_ready) begin
                axi.r_valid = 1'b1;
                axi.r_data  = data;
                axi.r_resp  = resp;
            end
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total = total + 1;
        if ({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready} !== 5'b0) begin
            bad = bad + 1;
            $display("FAIL reset_axi: got %b want 00000",
                     {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready});
        end
        total = total + 1;
        if ({mem_rvalid, mem_err, busy, mem_rdata} !== 35'd0) begin
            bad = bad + 1;
            $display("FAIL reset_mem: rvalid=%b err=%b busy=%b rdata=%h want all 0",
                     mem_rvalid, mem_err, busy, mem_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        axi.ar_ready = 1'b0;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_1003;
        #1;
        total = total + 1;
        if (mem_gnt !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL read_gnt: got %b want 1", mem_gnt);
        end
        axi.ar_ready = 1'b1;
        step();
        mem_req = 1'b0;
        total = total + 1;
        if (axi.ar_valid !== 1'b1 || axi.ar_addr !== 32'h0000_1000 || axi.ar_size !== 3'd2 ||
            axi.ar_len !== 8'd0 || axi.ar_burst !== 2'b01 || axi.ar_id !== 2'd0 || busy !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL read_ar: valid=%b addr=%h size=%0d len=%0d burst=%b id=%0d busy=%b want 1 00001000 2 0 01 0 1",
                     axi.ar_valid, axi.ar_addr, axi.ar_size, axi.ar_len, axi.ar_burst, axi.ar_id, busy);
        end
        axi.r_valid = 1'b1;
        axi.r_data  = 32'hDEAD_BEEF;
        axi.r_resp  = 2'b00;
        step();
        total = total + 1;
        if (axi.r_ready !== 1'b1 || axi.ar_valid !== 1'b0 || mem_rvalid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL read_rdata_phase: rready=%b arvalid=%b rvalid=%b want 1 0 0",
                     axi.r_ready, axi.ar_valid, mem_rvalid);
        end
        step();
        axi.r_valid = 1'b0;
        total = total + 1;
        if (mem_rvalid !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF || mem_err !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL read_done: rvalid=%b rdata=%h err=%b want 1 deadbeef 0",
                     mem_rvalid, mem_rdata, mem_err);
        end
        step();
        total = total + 1;
        if (mem_rvalid !== 1'b0 || busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL read_pulse: rvalid=%b busy=%b want 0 0", mem_rvalid, busy);
        end
    endtask

    task automatic test_write_w_first();
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b1;
        axi.b_valid  = 1'b0;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_2000;
        mem_wdata = 32'h1234_5678;
        mem_be    = 4'b0110;
        #1;
        total = total + 1;
        if (mem_gnt !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL wr_gnt: got %b want 1", mem_gnt);
        end
        step();
        mem_req = 1'b0;
        total = total + 1;
        if ({axi.aw_valid, axi.w_valid, axi.b_ready} !== 3'b110) begin
            bad = bad + 1;
            $display("FAIL wr_valids_rise: got %b want 110", {axi.aw_valid, axi.w_valid, axi.b_ready});
        end
        total = total + 1;
        if (axi.w_strb !== 4'b0110 || axi.w_data !== 32'h1234_5678 || axi.w_last !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL wr_w_payload: strb=%b data=%h last=%b want 0110 12345678 1",
                     axi.w_strb, axi.w_data, axi.w_last);
        end
        total = total + 1;
        if (axi.aw_addr !== 32'h0000_2000 || axi.aw_len !== 8'd0 || axi.aw_size !== 3'd2 ||
            axi.aw_burst !== 2'b01 || axi.aw_id !== 2'd0 ||
            {axi.aw_lock, axi.aw_cache, axi.aw_prot, axi.aw_qos, axi.aw_region, axi.aw_user} !== 17'd0) begin
            bad = bad + 1;
            $display("FAIL wr_aw_fields: addr=%h len=%0d size=%0d burst=%b id=%0d want 00002000 0 2 01 0",
                     axi.aw_addr, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_id);
        end
        for (int i = 2; i <= 4; i++) begin
            step();
            total = total + 1;
            if ({axi.aw_valid, axi.w_valid, axi.b_ready} !== 3'b100 || axi.aw_addr !== 32'h0000_2000) begin
                bad = bad + 1;
                $display("FAIL wr_aw_wait c%0d: valids=%b addr=%h want 100 00002000",
                         i, {axi.aw_valid, axi.w_valid, axi.b_ready}, axi.aw_addr);
            end
            if (i == 4) axi.aw_ready = 1'b1;
        end
        step();
        total = total + 1;
        if ({axi.aw_valid, axi.w_valid, axi.b_ready} !== 3'b000) begin
            bad = bad + 1;
            $display("FAIL wr_both_done: got %b want 000", {axi.aw_valid, axi.w_valid, axi.b_ready});
        end
        step();
        total = total + 1;
        if (axi.b_ready !== 1'b1 || mem_rvalid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL wr_bready: bready=%b rvalid=%b want 1 0", axi.b_ready, mem_rvalid);
        end
        axi.b_valid = 1'b1;
        axi.b_resp  = 2'b00;
        step();
        axi.b_valid = 1'b0;
        total = total + 1;
        if (mem_rvalid !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'hDEAD_BEEF || busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL wr_done: rvalid=%b err=%b rdata=%h busy=%b want 1 0 deadbeef 0",
                     mem_rvalid, mem_err, mem_rdata, busy);
        end
        step();
    endtask

    task automatic test_write_zero_be();
        int          lat;
        logic        done;
        logic        err;
        logic [3:0]  strb_seen;
        logic [31:0] rd;
        axi.aw_ready = 1'b1;
        axi.w_ready  = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_2006;
        mem_wdata = 32'hCAFE_F00D;
        mem_be    = 4'b0000;
        lat       = 0;
        done      = 1'b0;
        strb_seen = 4'hF;
        err       = 1'bx;
        rd        = 'x;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            mem_req     = 1'b0;
            lat         = lat + 1;
            axi.b_valid = 1'b0;
            if (axi.w_valid) strb_seen = axi.w_strb;
            if (mem_rvalid) begin
                done = 1'b1;
                err  = mem_err;
                rd   = mem_rdata;
            end else if (axi.b_ready) begin
                axi.b_valid = 1'b1;
                axi.b_resp  = 2'b10;
            end
        end
        total = total + 1;
        if (lat !== 4 || !done) begin
            bad = bad + 1;
            $display("FAIL wr0_latency: got %0d want 4", lat);
        end
        total = total + 1;
        if (strb_seen !== 4'b0000) begin
            bad = bad + 1;
            $display("FAIL wr0_strb: got %b want 0000", strb_seen);
        end
        total = total + 1;
        if (err !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
            bad = bad + 1;
            $display("FAIL wr0_slverr: err=%b rdata=%h want 1 deadbeef", err, rd);
        end
    endtask

    task automatic test_error();
        logic        g;
        int          lat;
        logic [31:0] rd;
        logic        err;
        run_read(32'h0000_3000, 32'h0000_0BAD, 2'b11, g, lat, rd, err);
        total = total + 1;
        if (g !== 1'b1 || lat !== 3 || rd !== 32'h0000_0BAD || err !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL err_decerr: gnt=%b lat=%0d rdata=%h err=%b want 1 3 00000bad 1",
                     g, lat, rd, err);
        end
        run_read(32'h0000_3004, 32'h0000_600D, 2'b00, g, lat, rd, err);
        total = total + 1;
        if (g !== 1'b1 || lat !== 3 || rd !== 32'h0000_600D || err !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL err_clear: gnt=%b lat=%0d rdata=%h err=%b want 1 3 0000600d 0",
                     g, lat, rd, err);
        end
    endtask

    task automatic test_back_to_back();
        int          first;
        int          second;
        int          overlap;
        int          gnt_busy;
        logic        gnt_at;
        logic [31:0] ar_seen;
        logic [31:0] rd;
        axi.aw_ready = 1'b1;
        axi.w_ready  = 1'b1;
        axi.ar_ready = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_0010;
        mem_wdata = 32'hA5A5_0010;
        mem_be    = 4'hF;
        first     = 0;
        second    = 0;
        overlap   = 0;
        gnt_busy  = 0;
        gnt_at    = 1'b0;
        ar_seen   = '0;
        rd        = '0;
        #1;
        total = total + 1;
        if (mem_gnt !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL b2b_gnt0: got %b want 1", mem_gnt);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            axi.b_valid = 1'b0;
            axi.r_valid = 1'b0;
            if (axi.b_ready) begin
                axi.b_valid = 1'b1;
                axi.b_resp  = 2'b00;
            end
            if (axi.r_ready) begin
                axi.r_valid = 1'b1;
                axi.r_data  = 32'h0000_1414;
                axi.r_resp  = 2'b00;
            end
            if ((axi.aw_valid || axi.w_valid || axi.b_ready) && (axi.ar_valid || axi.r_ready))
                overlap = overlap + 1;
            if (busy && mem_gnt) gnt_busy = gnt_busy + 1;
            if (axi.ar_valid) ar_seen = axi.ar_addr;
            if (mem_rvalid) begin
                if (first == 0) begin
                    first  = k;
                    gnt_at = mem_gnt;
                end else if (second == 0) begin
                    second = k;
                    rd     = mem_rdata;
                end
            end
            if (k == 1) begin
                mem_addr = 32'h0000_0014;
                mem_we   = 1'b0;
            end
            if (first != 0 && k == first + 1) mem_req = 1'b0;
        end
        total = total + 1;
        if (first !== 4 || gnt_at !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL b2b_first: rvalid cycle=%0d gnt=%b want 4 1", first, gnt_at);
        end
        total = total + 1;
        if (second !== 7 || rd !== 32'h0000_1414 || ar_seen !== 32'h0000_0014) begin
            bad = bad + 1;
            $display("FAIL b2b_second: rvalid cycle=%0d rdata=%h araddr=%h want 7 00001414 00000014",
                     second, rd, ar_seen);
        end
        total = total + 1;
        if (overlap !== 0 || gnt_busy !== 0) begin
            bad = bad + 1;
            $display("FAIL b2b_single: overlap=%0d gnt_while_busy=%0d want 0 0", overlap, gnt_busy);
        end
    endtask

    task automatic test_backpressure();
        axi.ar_ready = 1'b0;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0040;
        #1;
        total = total + 1;
        if (mem_gnt !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL bp_gnt: got %b want 1", mem_gnt);
        end
        // Keep requesting a different address; it must not be granted while busy.
        for (int c = 1; c <= 6; c++) begin
            step();
            mem_addr = 32'h0000_0080;
            total = total + 1;
            if ({axi.ar_valid, busy, mem_gnt, axi.r_ready} !== 4'b1100 ||
                axi.ar_addr !== 32'h0000_0040) begin
                bad = bad + 1;
                $display("FAIL bp_hold c%0d: arvalid,busy,gnt,rready=%b araddr=%h want 1100 00000040",
                         c, {axi.ar_valid, busy, mem_gnt, axi.r_ready}, axi.ar_addr);
            end
            if (c == 6) axi.ar_ready = 1'b1;
        end
        step();
        mem_req = 1'b0;
        axi.r_valid = 1'b1;
        axi.r_data  = 32'h0000_4040;
        axi.r_resp  = 2'b00;
        step();
        axi.r_valid = 1'b0;
        total = total + 1;
        if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h0000_4040) begin
            bad = bad + 1;
            $display("FAIL bp_done: rvalid=%b rdata=%h want 1 00004040", mem_rvalid, mem_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_write();
        logic        g;
        int          lat;
        logic [31:0] rd;
        logic        err;
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b0;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_5000;
        mem_wdata = 32'h5555_AAAA;
        mem_be    = 4'hF;
        step();
        mem_req = 1'b0;
        total = total + 1;
        if (axi.aw_valid !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL rstmid_pre: awvalid=%b want 1", axi.aw_valid);
        end
        rst_n = 1'b0;
        step();
        total = total + 1;
        if ({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready,
             mem_rvalid, busy} !== 7'b0 || mem_rdata !== 32'd0) begin
            bad = bad + 1;
            $display("FAIL rstmid_clear: valids=%b rvalid=%b busy=%b rdata=%h want 00000 0 0 0",
                     {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready},
                     mem_rvalid, busy, mem_rdata);
        end
        rst_n = 1'b1;
        axi.aw_ready = 1'b1;
        axi.w_ready  = 1'b1;
        run_read(32'h0000_6008, 32'h6008_6008, 2'b00, g, lat, rd, err);
        total = total + 1;
        if (g !== 1'b1 || lat !== 3 || rd !== 32'h6008_6008 || err !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL rstmid_read: gnt=%b lat=%0d rdata=%h err=%b want 1 3 60086008 0",
                     g, lat, rd, err);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b0;
        axi.b_valid  = 1'b0;
        axi.b_resp   = 2'b00;
        axi.b_id     = 2'd3;
        axi.b_user   = 1'b0;
        axi.ar_ready = 1'b0;
        axi.r_valid  = 1'b0;
        axi.r_data   = '0;
        axi.r_resp   = 2'b00;
        axi.r_id     = 2'd3;
        axi.r_last   = 1'b0;
        axi.r_user   = 1'b0;

        test_reset();
        test_read();
        test_write_w_first();
        test_write_zero_be();
        test_error();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_write();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accel_axi_master_bridge.md
Name: accel_axi_master_bridge

Overview:
- Converts the accelerator's simple memory-request bus (req/gnt/rvalid) into single-beat AXI4 master transactions.
- Lets the accelerator fetch operands from, and write results to, system memory.
- It is the initiator counterpart to the AXI-slave-to-memory conversion in the accelerator top wrapper.
- Sits between the accelerator core and a master port of the SoC AXI interconnect.
- One transaction outstanding at a time.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 32, AXI and memory-bus data width; must be a power of two, at least 32.
- AXI_ID_WIDTH, 2, ID width of the master port.
- AXI_USER_WIDTH, 1, user-field width.
- AXI_ID, 0, constant ID driven on AW and AR.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- mem_req  in  1  request valid from the accelerator
- mem_gnt  out  1  request accepted this cycle
- mem_addr  in  AXI_ADDR_WIDTH  byte address
- mem_we  in  1  1 = write, 0 = read
- mem_be  in  AXI_DATA_WIDTH/8  byte enables; writes only
- mem_wdata  in  AXI_DATA_WIDTH  write data
- mem_rvalid  out  1  one-cycle completion pulse, for both reads and writes
- mem_rdata  out  AXI_DATA_WIDTH  read data; valid while mem_rvalid=1
- mem_err  out  1  error status; valid while mem_rvalid=1
- busy  out  1  FSM not in IDLE
- axi_master  AXI_BUS.Master  -  AXI4 master port

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state IDLE; AWVALID, WVALID, ARVALID, BREADY, RREADY, mem_rvalid, mem_err, busy all 0; mem_rdata 0.
- Reset mid-transaction: return to IDLE and drop all valids. A system-wide reset is assumed, so AXI slave state is not preserved.
- FSM states: IDLE, WRITE, WR_RESP, READ, RD_DATA.
- Grant: mem_gnt = mem_req && state==IDLE (combinational).
- On grant, latch the following and leave IDLE:
  - address, with the low log2(DW/8) bits forced to 0;
  - we, be, wdata.
- IDLE -> WRITE when we=1; IDLE -> READ when we=0.
- WRITE:
  - AWVALID and WVALID rise together, registered, in the first cycle after grant.
  - Each valid holds, with stable payload, until its own handshake.
  - AW and W may complete in either order or together; track completion with aw_done/w_done flags.
  - When both are done, go to WR_RESP. The flags clear on entry to IDLE.
- WR_RESP: BREADY=1. On the B handshake, go to IDLE.
- READ: ARVALID=1 until the AR handshake, then go to RD_DATA.
- RD_DATA: RREADY=1. On the R handshake, go to IDLE.
- Completion:
  - The cycle after a B or R handshake: mem_rvalid=1 for exactly one cycle.
  - mem_err = RESP[1], so SLVERR and DECERR both flag an error.
  - For reads, mem_rdata = RDATA captured at the handshake. For writes, mem_rdata holds its previous value.
- Latency: with the slave always ready, grant to mem_rvalid is 3 cycles for a read and 4 cycles for a write.
- Back-to-back: a new request may be granted in the same cycle mem_rvalid is high.
- Fixed AXI fields:
  - LEN=0, SIZE=log2(DW/8), BURST=INCR, WLAST=1, WSTRB=latched be.
  - LOCK, CACHE, PROT, QOS, REGION, USER all 0.
  - ID=AXI_ID.
  - A response with an unexpected ID is still accepted.
- Read responses with RLAST=0 are accepted as the single beat.
- Write with be=0: still issued on AXI, with WSTRB=0.
- The accelerator must hold its mem_* inputs stable while mem_req=1 and mem_gnt=0.

Decomposition:
- Shared package (cfg_types_pkg): typedef enum axi_mst_state_t {IDLE, WRITE, WR_RESP, READ, RD_DATA}.
- Same package: localparams AXI_BURST_INCR=2'b01, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
- No sub-module. The FSM and datapath registers stay in one module.

Test Plan:
- Read, slave always ready: req addr=0x0000_1003 -> ARADDR=0x0000_1000, SIZE=2, LEN=0; RDATA=0xDEAD_BEEF, RESP=OKAY -> mem_rvalid pulse 3 cycles after gnt, mem_rdata=0xDEAD_BEEF, mem_err=0.
- Write, W accepted 3 cycles before AW: addr=0x2000, wdata=0x1234_5678, be=4'b0110 -> WSTRB=0110, WVALID held until handshake, BREADY only after both handshakes, mem_rvalid once B arrives.
- Error response: read returning RESP=DECERR -> mem_rvalid=1, mem_err=1; next read returning OKAY -> mem_err=0.
- Back-to-back: mem_req held high for write 0x10, then read 0x14 -> second gnt in the same cycle as the first mem_rvalid; exactly one transaction outstanding on AXI at all times.
- Backpressure: ARREADY low for 5 cycles -> ARVALID and ARADDR stable for all 6 cycles; busy=1 throughout; mem_gnt=0 to any new request.
- Reset mid-write: rst_n=0 while AWVALID=1 -> next cycle all valids 0, state IDLE, mem_rvalid=0; a subsequent read completes normally.
